// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank writeback scheduler: default geometry,
// grant encoding and scoreboard counter limit.
package regbank_pkg;

  localparam int unsigned DEPTH_DEF     = 15;
  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned ADD_WIDTH_DEF = 5;
  localparam int unsigned CNT_W_DEF     = 2;

  localparam int unsigned REG_ZERO = 0;

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam int unsigned CNT_MAX = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/regbank_wb_scheduler_if.sv
// Writeback, scoreboard-mark, hazard and register-bank write signals of the scheduler.
interface regbank_wb_scheduler_if #(
  parameter int unsigned WIDTH     = regbank_pkg::WIDTH_DEF,
  parameter int unsigned ADD_WIDTH = regbank_pkg::ADD_WIDTH_DEF
);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADD_WIDTH-1:0] alu_reg;
  logic [WIDTH-1:0]     alu_data;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [ADD_WIDTH-1:0] mem_reg;
  logic [WIDTH-1:0]     mem_data;

  logic                 mark_valid;
  logic                 mark_ready;
  logic [ADD_WIDTH-1:0] mark_reg;

  logic [ADD_WIDTH-1:0] rd_reg1;
  logic [ADD_WIDTH-1:0] rd_reg2;
  logic                 stall;

  logic                 w_en;
  logic [ADD_WIDTH-1:0] w_reg;
  logic [WIDTH-1:0]     w_data;
  logic                 err;

  // Pipeline side: requesters, decode and the register bank.
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output mark_valid, mark_reg, rd_reg1, rd_reg2,
    input  alu_ready, mem_ready, mark_ready, stall,
    input  w_en, w_reg, w_data, err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  mark_valid, mark_reg, rd_reg1, rd_reg2,
    output alu_ready, mem_ready, mark_ready, stall,
    output w_en, w_reg, w_data, err
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Per-register pending-write counters: incremented by decode marks, decremented when
// the registered write lands; drives the decode read-hazard stall and mark_ready.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADD_WIDTH = ADD_WIDTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mark_valid_i,
  input  logic [ADD_WIDTH-1:0] mark_reg_i,
  output logic                 mark_ready_o,
  input  logic                 clr_en_i,
  input  logic [ADD_WIDTH-1:0] clr_reg_i,
  input  logic [ADD_WIDTH-1:0] rd_reg1_i,
  input  logic [ADD_WIDTH-1:0] rd_reg2_i,
  output logic                 stall_o
);

  // One slot per encodable address so any index is legal; slots outside 1..DEPTH-1
  // are tied to zero and drop out in synthesis.
  localparam int unsigned NumSlots = 2 ** ADD_WIDTH;
  localparam logic [ADD_WIDTH-1:0] DepthA = ADD_WIDTH'(DEPTH);
  localparam logic [ADD_WIDTH-1:0] RegZeroA = ADD_WIDTH'(REG_ZERO);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q [NumSlots];
  logic [CNT_W-1:0] cnt_d [NumSlots];
  logic             mark_inc;

  function automatic logic in_range(input logic [ADD_WIDTH-1:0] r);
    return (r != RegZeroA) && (r < DepthA);
  endfunction

  always_comb begin
    mark_ready_o = !(in_range(mark_reg_i) && (cnt_q[mark_reg_i] == CntMax));
    mark_inc     = mark_valid_i && mark_ready_o && in_range(mark_reg_i);
    stall_o      = (in_range(rd_reg1_i) && (cnt_q[rd_reg1_i] != '0)) ||
                   (in_range(rd_reg2_i) && (cnt_q[rd_reg2_i] != '0));
  end

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((i >= 1) && (i < DEPTH)) begin
        logic inc;
        logic dec;
        inc = mark_inc && (mark_reg_i == ADD_WIDTH'(i));
        dec = clr_en_i && (clr_reg_i == ADD_WIDTH'(i));
        if (inc && !dec) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (dec && !inc && (cnt_q[i] != '0)) begin
          // Writes without a prior mark leave an empty counter at zero.
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumSlots; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Round-robin writeback arbiter between ALU and load stages, owning the single
// registered register-bank write port, the sticky address error and the scoreboard.
module regbank_wb_scheduler
  import regbank_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned ADD_WIDTH = ADD_WIDTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  regbank_wb_scheduler_if.slave bus
);

  localparam logic [ADD_WIDTH-1:0] DepthA = ADD_WIDTH'(DEPTH);
  localparam logic [ADD_WIDTH-1:0] RegZeroA = ADD_WIDTH'(REG_ZERO);

  logic                 gnt_alu;
  logic                 gnt_mem;
  logic                 accept;
  logic                 wr_ok;
  logic                 req_oob;
  logic                 mark_oob;
  logic [ADD_WIDTH-1:0] sel_reg;
  logic [WIDTH-1:0]     sel_data;

  // rr_q names the requester that wins the next contended cycle.
  logic                 rr_q, rr_d;
  logic                 w_en_q, w_en_d;
  logic [ADD_WIDTH-1:0] w_reg_q, w_reg_d;
  logic [WIDTH-1:0]     w_data_q, w_data_d;
  logic                 err_q, err_d;

  always_comb begin
    gnt_alu  = bus.alu_valid && (!bus.mem_valid || (rr_q == GNT_ALU));
    gnt_mem  = bus.mem_valid && !gnt_alu;
    accept   = gnt_alu || gnt_mem;
    sel_reg  = gnt_mem ? bus.mem_reg : bus.alu_reg;
    sel_data = gnt_mem ? bus.mem_data : bus.alu_data;
    wr_ok    = accept && (sel_reg != RegZeroA) && (sel_reg < DepthA);
    req_oob  = accept && (sel_reg >= DepthA);
    mark_oob = bus.mark_valid && (bus.mark_reg >= DepthA);

    rr_d = rr_q;
    if (bus.alu_valid && bus.mem_valid) begin
      rr_d = gnt_alu ? GNT_MEM : GNT_ALU;
    end

    w_en_d   = wr_ok;
    w_reg_d  = wr_ok ? sel_reg : w_reg_q;
    w_data_d = wr_ok ? sel_data : w_data_q;
    err_d    = err_q || req_oob || mark_oob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= GNT_ALU;
      w_en_q   <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      w_en_q   <= w_en_d;
      w_reg_q  <= w_reg_d;
      w_data_q <= w_data_d;
      err_q    <= err_d;
    end
  end

  assign bus.alu_ready = gnt_alu;
  assign bus.mem_ready = gnt_mem;
  assign bus.w_en      = w_en_q;
  assign bus.w_reg     = w_reg_q;
  assign bus.w_data    = w_data_q;
  assign bus.err       = err_q;

  regbank_scoreboard #(
    .DEPTH     (DEPTH),
    .ADD_WIDTH (ADD_WIDTH),
    .CNT_W     (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .mark_valid_i (bus.mark_valid),
    .mark_reg_i   (bus.mark_reg),
    .mark_ready_o (bus.mark_ready),
    .clr_en_i     (w_en_q),
    .clr_reg_i    (w_reg_q),
    .rd_reg1_i    (bus.rd_reg1),
    .rd_reg2_i    (bus.rd_reg2),
    .stall_o      (bus.stall)
  );

endmodule
